// File: rtl/datactrl_arb_if.sv
// Signal bundle between the data arbiter, the ROB store port,
// the load-buffer ports and the RAM controller data port.
interface datactrl_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NLOAD  = 2
);
  logic                    rdy_in;
  logic                    flush_in;
  logic                    rob_st_en_in;
  logic [2:0]              rob_st_width_in;
  logic [ADDR_W-1:0]       rob_st_addr_in;
  logic [DATA_W-1:0]       rob_st_data_in;
  logic                    st_ack_out;
  logic [NLOAD-1:0]        ld_en_in;
  logic [3*NLOAD-1:0]      ld_width_in;
  logic [NLOAD-1:0]        ld_sgn_in;
  logic [ADDR_W*NLOAD-1:0] ld_addr_in;
  logic [NLOAD-1:0]        ld_ack_out;
  logic [DATA_W-1:0]       ld_data_out;
  logic                    ram_en_out;
  logic                    ram_rw_out;
  logic [2:0]              ram_width_out;
  logic [ADDR_W-1:0]       ram_addr_out;
  logic [DATA_W-1:0]       ram_data_out;
  logic                    ram_rdy_in;
  logic [DATA_W-1:0]       ram_data_in;

  modport master (
    input  rdy_in, flush_in,
    input  rob_st_en_in, rob_st_width_in,
    input  rob_st_addr_in, rob_st_data_in,
    input  ld_en_in, ld_width_in,
    input  ld_sgn_in, ld_addr_in,
    input  ram_rdy_in, ram_data_in,
    output st_ack_out, ld_ack_out, ld_data_out,
    output ram_en_out, ram_rw_out, ram_width_out,
    output ram_addr_out, ram_data_out
  );

  modport slave (
    output rdy_in, flush_in,
    output rob_st_en_in, rob_st_width_in,
    output rob_st_addr_in, rob_st_data_in,
    output ld_en_in, ld_width_in,
    output ld_sgn_in, ld_addr_in,
    output ram_rdy_in, ram_data_in,
    input  st_ack_out, ld_ack_out, ld_data_out,
    input  ram_en_out, ram_rw_out, ram_width_out,
    input  ram_addr_out, ram_data_out
  );
endinterface

// File: rtl/datactrl_arb.sv
// Data-side RAM arbiter: committed stores beat round-robin loads,
// one transaction in flight, load data extended on return.
module datactrl_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NLOAD  = 2
) (
  input  logic           clk_in,
  input  logic           rst_n_in,
  datactrl_arb_if.master bus
);

  localparam int PW  = (NLOAD > 1) ? $clog2(NLOAD) : 1;
  localparam int PW1 = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD,
    DRAIN
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     rr_q, rr_d;
  logic [PW-1:0]     id_q, id_d;
  logic              sgn_q, sgn_d;
  logic [2:0]        lw_q, lw_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_rw_q, ram_rw_d;
  logic [2:0]        ram_w_q, ram_w_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [DATA_W-1:0] ram_wd_q, ram_wd_d;
  logic              st_ack_q, st_ack_d;
  logic [NLOAD-1:0]  ld_ack_q, ld_ack_d;
  logic [DATA_W-1:0] ld_data_q, ld_data_d;

  logic              st_req;
  logic [NLOAD-1:0]  ld_req;
  logic              ld_hit;
  logic [PW-1:0]     gnt;
  logic [PW1-1:0]    sum;
  logic [PW1-1:0]    nxt;
  logic [2:0]        g_w;
  logic              g_s;
  logic [ADDR_W-1:0] g_a;

  // Sign/zero-extend raw read data from the byte count.
  function automatic logic [DATA_W-1:0] extend(
    input logic [DATA_W-1:0] raw,
    input logic [2:0]        w,
    input logic              s
  );
    logic [DATA_W-1:0] r;
    logic              top;
    int                hb;
    unique case (1'b1)
      (w == 3'd1): begin
        top = s & raw[7];
        hb  = 7;
      end
      (w == 3'd2): begin
        top = s & raw[15];
        hb  = 15;
      end
      default: begin
        top = s & raw[31];
        hb  = 31;
      end
    endcase
    for (int b = 0; b < DATA_W; b++) begin
      r[b] = (b > hb) ? top : raw[b];
    end
    return r;
  endfunction

  // Requests minus those acked this cycle; rotate from rr_q.
  always_comb begin
    st_req = bus.rob_st_en_in & ~st_ack_q;
    ld_req = bus.ld_en_in & ~ld_ack_q;
    ld_hit = 1'b0;
    gnt    = '0;
    sum    = '0;
    for (int i = 0; i < NLOAD; i++) begin
      sum = {1'b0, rr_q} + PW1'(i);
      if (sum >= PW1'(NLOAD)) begin
        sum = sum - PW1'(NLOAD);
      end
      if (!ld_hit && ld_req[sum[PW-1:0]]) begin
        ld_hit = 1'b1;
        gnt    = sum[PW-1:0];
      end
    end
    nxt = {1'b0, gnt} + PW1'(1);
    if (nxt >= PW1'(NLOAD)) begin
      nxt = '0;
    end
  end

  // Mux out the granted channel's request fields.
  always_comb begin
    g_w = '0;
    g_s = 1'b0;
    g_a = '0;
    for (int j = 0; j < NLOAD; j++) begin
      if (gnt == PW'(j)) begin
        g_w = bus.ld_width_in[3*j +: 3];
        g_s = bus.ld_sgn_in[j];
        g_a = bus.ld_addr_in[ADDR_W*j +: ADDR_W];
      end
    end
  end

  // Next-state and next-output logic; rdy_in low holds everything.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    id_d      = id_q;
    sgn_d     = sgn_q;
    lw_d      = lw_q;
    ram_en_d  = ram_en_q;
    ram_rw_d  = ram_rw_q;
    ram_w_d   = ram_w_q;
    ram_a_d   = ram_a_q;
    ram_wd_d  = ram_wd_q;
    st_ack_d  = st_ack_q;
    ld_ack_d  = ld_ack_q;
    ld_data_d = ld_data_q;
    if (bus.rdy_in) begin
      st_ack_d = 1'b0;
      ld_ack_d = '0;
      unique case (state_q)
        IDLE: begin
          if (st_req) begin
            state_d  = WR;
            ram_en_d = 1'b1;
            ram_rw_d = 1'b1;
            ram_w_d  = bus.rob_st_width_in;
            ram_a_d  = bus.rob_st_addr_in;
            ram_wd_d = bus.rob_st_data_in;
          end else if (ld_hit && !bus.flush_in) begin
            state_d  = RD;
            ram_en_d = 1'b1;
            ram_rw_d = 1'b0;
            ram_w_d  = g_w;
            ram_a_d  = g_a;
            id_d     = gnt;
            sgn_d    = g_s;
            lw_d     = g_w;
            rr_d     = nxt[PW-1:0];
          end
        end
        WR: begin
          if (bus.ram_rdy_in) begin
            state_d  = IDLE;
            ram_en_d = 1'b0;
            st_ack_d = 1'b1;
          end
        end
        RD: begin
          if (bus.ram_rdy_in) begin
            state_d  = IDLE;
            ram_en_d = 1'b0;
            if (!bus.flush_in) begin
              ld_ack_d[id_q] = 1'b1;
              ld_data_d = extend(bus.ram_data_in, lw_q, sgn_q);
            end
          end else if (bus.flush_in) begin
            state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (bus.ram_rdy_in) begin
            state_d  = IDLE;
            ram_en_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      id_q      <= '0;
      sgn_q     <= 1'b0;
      lw_q      <= '0;
      ram_en_q  <= 1'b0;
      ram_rw_q  <= 1'b0;
      ram_w_q   <= '0;
      ram_a_q   <= '0;
      ram_wd_q  <= '0;
      st_ack_q  <= 1'b0;
      ld_ack_q  <= '0;
      ld_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      id_q      <= id_d;
      sgn_q     <= sgn_d;
      lw_q      <= lw_d;
      ram_en_q  <= ram_en_d;
      ram_rw_q  <= ram_rw_d;
      ram_w_q   <= ram_w_d;
      ram_a_q   <= ram_a_d;
      ram_wd_q  <= ram_wd_d;
      st_ack_q  <= st_ack_d;
      ld_ack_q  <= ld_ack_d;
      ld_data_q <= ld_data_d;
    end
  end

  assign bus.st_ack_out    = st_ack_q;
  assign bus.ld_ack_out    = ld_ack_q;
  assign bus.ld_data_out   = ld_data_q;
  assign bus.ram_en_out    = ram_en_q;
  assign bus.ram_rw_out    = ram_rw_q;
  assign bus.ram_width_out = ram_w_q;
  assign bus.ram_addr_out  = ram_a_q;
  assign bus.ram_data_out  = ram_wd_q;

endmodule

// File: tb/tb_datactrl_arb.sv
// Bench for datactrl_arb: extension table, directed corner
// sequences and randomized traffic against a simple model.
module tb_datactrl_arb;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  datactrl_arb_if #(.ADDR_W(32), .DATA_W(32), .NLOAD(2)) bus ();

  datactrl_arb #(.ADDR_W(32), .DATA_W(32), .NLOAD(2)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  typedef struct {
    int          ch;
    logic [2:0]  w;
    bit          s;
    logic [31:0] raw;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[10];
  int   exp_seq[6];
  int   who;
  bit   ok;
  int   m_rr;
  bit   pst;
  bit [1:0] pld;
  int   p;
  int   lat;
  logic [2:0]  sw;
  logic [31:0] sa, sd;
  logic [2:0]  lw[2];
  bit          ls[2];
  logic [31:0] la[2], lr[2];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] m_ext(input logic [31:0] raw,
                                        input int w, input bit s);
    longint v, m;
    int nb;
    nb = (w == 1) ? 8 : (w == 2) ? 16 : 32;
    m = longint'(1) << nb;
    v = longint'({32'd0, raw}) % m;
    if (s && v >= m / 2) v = v - m;
    return v[31:0];
  endfunction

  task automatic idle_inputs();
    bus.rdy_in          = 1'b1;
    bus.flush_in        = 1'b0;
    bus.rob_st_en_in    = 1'b0;
    bus.rob_st_width_in = '0;
    bus.rob_st_addr_in  = '0;
    bus.rob_st_data_in  = '0;
    bus.ld_en_in        = '0;
    bus.ld_width_in     = '0;
    bus.ld_sgn_in       = '0;
    bus.ld_addr_in      = '0;
    bus.ram_rdy_in      = 1'b0;
    bus.ram_data_in     = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic set_ld(input int ch, input logic [2:0] w,
                        input bit s, input logic [31:0] a);
    bus.ld_en_in[ch]           = 1'b1;
    bus.ld_width_in[3*ch +: 3] = w;
    bus.ld_sgn_in[ch]          = s;
    bus.ld_addr_in[32*ch +: 32] = a;
  endtask

  task automatic set_st(input logic [2:0] w, input logic [31:0] a,
                        input logic [31:0] d);
    bus.rob_st_en_in    = 1'b1;
    bus.rob_st_width_in = w;
    bus.rob_st_addr_in  = a;
    bus.rob_st_data_in  = d;
  endtask

  task automatic wait_en(input string nm, output bit okv);
    okv = 1'b0;
    for (int i = 0; i < 20 && !okv; i++) begin
      if (bus.ram_en_out === 1'b1) okv = 1'b1;
      else @(negedge clk);
    end
    chk({nm, "_en_seen"}, okv, 1);
  endtask

  task automatic serve(input string nm, input logic [31:0] raw,
                       output int w_o);
    bit okv;
    wait_en(nm, okv);
    w_o = 9;
    if (!okv) return;
    bus.ram_rdy_in  = 1'b1;
    bus.ram_data_in = raw;
    @(negedge clk);
    bus.ram_rdy_in = 1'b0;
    if (bus.st_ack_out && bus.ld_ack_out == 2'b00) w_o = 2;
    else if (!bus.st_ack_out && bus.ld_ack_out == 2'b01) w_o = 0;
    else if (!bus.st_ack_out && bus.ld_ack_out == 2'b10) w_o = 1;
    else w_o = 7;
  endtask

  initial begin
    tbl[0] = '{0, 3'd1, 1'b1, 32'h000000F0, 32'hFFFFFFF0};
    tbl[1] = '{0, 3'd1, 1'b0, 32'h000000F0, 32'h000000F0};
    tbl[2] = '{0, 3'd2, 1'b1, 32'h00008001, 32'hFFFF8001};
    tbl[3] = '{1, 3'd2, 1'b0, 32'h00008001, 32'h00008001};
    tbl[4] = '{1, 3'd4, 1'b1, 32'h80000000, 32'h80000000};
    tbl[5] = '{0, 3'd1, 1'b1, 32'h1234567F, 32'h0000007F};
    tbl[6] = '{1, 3'd3, 1'b1, 32'h80000001, 32'h80000001};
    tbl[7] = '{0, 3'd0, 1'b0, 32'hCAFEBABE, 32'hCAFEBABE};
    tbl[8] = '{1, 3'd2, 1'b1, 32'hABCD7FFF, 32'h00007FFF};
    tbl[9] = '{0, 3'd1, 1'b0, 32'hFFFFFF80, 32'h00000080};
    exp_seq = '{2, 0, 1, 0, 1, 0};

    do_reset();
    chk("rst_ram_en", bus.ram_en_out, 0);
    chk("rst_ram_rw", bus.ram_rw_out, 0);
    chk("rst_ram_width", bus.ram_width_out, 0);
    chk("rst_ram_addr", bus.ram_addr_out, 0);
    chk("rst_ram_data", bus.ram_data_out, 0);
    chk("rst_st_ack", bus.st_ack_out, 0);
    chk("rst_ld_ack", bus.ld_ack_out, 0);
    chk("rst_ld_data", bus.ld_data_out, 0);

    set_st(3'd4, 32'h100, 32'hDEADBEEF);
    @(negedge clk);
    chk("st_en", bus.ram_en_out, 1);
    chk("st_rw", bus.ram_rw_out, 1);
    chk("st_addr", bus.ram_addr_out, 32'h100);
    chk("st_data", bus.ram_data_out, 32'hDEADBEEF);
    chk("st_width", bus.ram_width_out, 4);
    repeat (2) @(negedge clk);
    chk("st_en_hold", bus.ram_en_out, 1);
    chk("st_no_early_ack", bus.st_ack_out, 0);
    bus.ram_rdy_in = 1'b1;
    @(negedge clk);
    bus.ram_rdy_in   = 1'b0;
    bus.rob_st_en_in = 1'b0;
    chk("st_ack", bus.st_ack_out, 1);
    chk("st_en_drop", bus.ram_en_out, 0);
    @(negedge clk);
    chk("st_ack_once", bus.st_ack_out, 0);

    foreach (tbl[k]) begin
      set_ld(tbl[k].ch, tbl[k].w, tbl[k].s, 32'h200 + 4 * k);
      @(negedge clk);
      chk($sformatf("tbl%0d_en", k), bus.ram_en_out, 1);
      chk($sformatf("tbl%0d_rw", k), bus.ram_rw_out, 0);
      chk($sformatf("tbl%0d_addr", k), bus.ram_addr_out, 32'h200 + 4 * k);
      chk($sformatf("tbl%0d_width", k), bus.ram_width_out, tbl[k].w);
      bus.ram_rdy_in  = 1'b1;
      bus.ram_data_in = tbl[k].raw;
      @(negedge clk);
      bus.ram_rdy_in = 1'b0;
      bus.ld_en_in   = '0;
      chk($sformatf("tbl%0d_ack", k), bus.ld_ack_out, 1 << tbl[k].ch);
      chk($sformatf("tbl%0d_data", k), bus.ld_data_out, tbl[k].exp);
      @(negedge clk);
    end

    do_reset();
    set_st(3'd4, 32'h300, 32'h1);
    set_ld(0, 3'd4, 1'b0, 32'h304);
    set_ld(1, 3'd4, 1'b0, 32'h308);
    for (int k = 0; k < 6; k++) begin
      serve("prio", 32'h11110000 + k, who);
      if (who == 2) bus.rob_st_en_in = 1'b0;
      chk($sformatf("prio_grant%0d", k), who, exp_seq[k]);
    end
    bus.ld_en_in = '0;
    @(negedge clk);

    do_reset();
    set_ld(0, 3'd1, 1'b1, 32'h400);
    @(negedge clk);
    chk("fl_en", bus.ram_en_out, 1);
    bus.flush_in = 1'b1;
    @(negedge clk);
    bus.flush_in = 1'b0;
    bus.ld_en_in = '0;
    chk("fl_en_hold1", bus.ram_en_out, 1);
    @(negedge clk);
    chk("fl_en_hold2", bus.ram_en_out, 1);
    bus.ram_rdy_in  = 1'b1;
    bus.ram_data_in = 32'hF0;
    @(negedge clk);
    bus.ram_rdy_in = 1'b0;
    chk("fl_en_drop", bus.ram_en_out, 0);
    chk("fl_no_ack", bus.ld_ack_out, 0);
    set_ld(1, 3'd2, 1'b1, 32'h404);
    @(negedge clk);
    chk("fl_new_en", bus.ram_en_out, 1);
    chk("fl_new_addr", bus.ram_addr_out, 32'h404);
    bus.ram_rdy_in  = 1'b1;
    bus.ram_data_in = 32'h8001;
    @(negedge clk);
    bus.ram_rdy_in = 1'b0;
    bus.ld_en_in   = '0;
    chk("fl_new_ack", bus.ld_ack_out, 2'b10);
    chk("fl_new_data", bus.ld_data_out, 32'hFFFF8001);
    @(negedge clk);
    set_ld(0, 3'd4, 1'b0, 32'h408);
    bus.flush_in = 1'b1;
    @(negedge clk);
    bus.flush_in = 1'b0;
    chk("fl_idle_nogrant", bus.ram_en_out, 0);
    serve("fl_idle", 32'h5, who);
    bus.ld_en_in = '0;
    chk("fl_idle_later", who, 0);
    @(negedge clk);

    set_st(3'd2, 32'h410, 32'hBEEF);
    @(negedge clk);
    chk("fs_en", bus.ram_en_out, 1);
    bus.flush_in = 1'b1;
    @(negedge clk);
    bus.flush_in   = 1'b0;
    bus.ram_rdy_in = 1'b1;
    @(negedge clk);
    bus.ram_rdy_in   = 1'b0;
    bus.rob_st_en_in = 1'b0;
    chk("fs_ack", bus.st_ack_out, 1);
    @(negedge clk);

    set_ld(0, 3'd4, 1'b0, 32'h500);
    @(negedge clk);
    chk("sv_en", bus.ram_en_out, 1);
    bus.rdy_in      = 1'b0;
    bus.ram_rdy_in  = 1'b1;
    bus.ram_data_in = 32'h12345678;
    @(negedge clk);
    bus.ram_rdy_in = 1'b0;
    bus.rdy_in     = 1'b1;
    chk("sv_freeze_en", bus.ram_en_out, 1);
    chk("sv_freeze_ack", bus.ld_ack_out, 0);
    @(negedge clk);
    chk("sv_pulse_lost", bus.ram_en_out, 1);
    bus.ram_rdy_in = 1'b1;
    @(negedge clk);
    bus.ram_rdy_in = 1'b0;
    bus.ld_en_in   = '0;
    chk("sv_ack", bus.ld_ack_out, 2'b01);
    chk("sv_data", bus.ld_data_out, 32'h12345678);
    bus.rdy_in = 1'b0;
    @(negedge clk);
    chk("sv_ack_frozen", bus.ld_ack_out, 2'b01);
    bus.rdy_in = 1'b1;
    @(negedge clk);
    chk("sv_ack_clear", bus.ld_ack_out, 0);

    set_ld(0, 3'd4, 1'b0, 32'h600);
    @(negedge clk);
    chk("rs_en", bus.ram_en_out, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_async_en", bus.ram_en_out, 0);
    chk("rs_async_addr", bus.ram_addr_out, 0);
    chk("rs_async_data", bus.ld_data_out, 0);
    bus.ld_en_in = '0;
    @(negedge clk);
    rst_n = 1'b1;
    set_ld(0, 3'd1, 1'b1, 32'h604);
    set_ld(1, 3'd1, 1'b1, 32'h608);
    serve("rs_a", 32'h80, who);
    bus.ld_en_in[0] = 1'b0;
    chk("rs_rr_first", who, 0);
    chk("rs_data", bus.ld_data_out, 32'hFFFFFF80);
    serve("rs_b", 32'h7F, who);
    bus.ld_en_in = '0;
    chk("rs_rr_second", who, 1);
    @(negedge clk);

    do_reset();
    m_rr = 0;
    for (int r = 0; r < 60; r++) begin
      pst = 1'($urandom_range(0, 1));
      pld = 2'($urandom_range(0, 3));
      if (!pst && pld == 2'b00) pld = 2'b01;
      if (pst) begin
        p  = $urandom_range(0, 2);
        sw = (p == 0) ? 3'd1 : (p == 1) ? 3'd2 : 3'd4;
        sa = $urandom;
        sd = $urandom;
        set_st(sw, sa, sd);
      end
      for (int c = 0; c < 2; c++) begin
        if (pld[c]) begin
          lw[c] = 3'($urandom_range(0, 7));
          ls[c] = 1'($urandom_range(0, 1));
          la[c] = $urandom;
          lr[c] = $urandom;
          set_ld(c, lw[c], ls[c], la[c]);
        end
      end
      while (pst || pld != 2'b00) begin
        if (pst) p = 2;
        else begin
          p = -1;
          for (int k = 0; k < 2; k++) begin
            if (p < 0 && pld[(m_rr + k) % 2]) p = (m_rr + k) % 2;
          end
        end
        wait_en("rnd", ok);
        if (!ok) break;
        chk("rnd_rw", bus.ram_rw_out, p == 2);
        chk("rnd_addr", bus.ram_addr_out, (p == 2) ? sa : la[p]);
        if (p == 2) begin
          chk("rnd_st_data", bus.ram_data_out, sd);
          chk("rnd_st_width", bus.ram_width_out, sw);
        end
        lat = $urandom_range(0, 3);
        for (int t = 0; t < lat; t++) begin
          bus.rdy_in = ($urandom_range(0, 2) != 0);
          @(negedge clk);
          chk("rnd_en_hold", bus.ram_en_out, 1);
        end
        bus.rdy_in      = 1'b1;
        bus.ram_rdy_in  = 1'b1;
        bus.ram_data_in = (p == 2) ? $urandom : lr[p];
        @(negedge clk);
        bus.ram_rdy_in = 1'b0;
        if (p == 2) begin
          chk("rnd_st_ack", {bus.st_ack_out, bus.ld_ack_out}, 3'b100);
          bus.rob_st_en_in = 1'b0;
          pst = 1'b0;
        end else begin
          chk("rnd_ld_ack", {bus.st_ack_out, bus.ld_ack_out}, 1 << p);
          chk("rnd_ld_data", bus.ld_data_out,
              m_ext(lr[p], int'(lw[p]), ls[p]));
          bus.ld_en_in[p] = 1'b0;
          pld[p] = 1'b0;
          m_rr = (p + 1) % 2;
        end
      end
      bus.rob_st_en_in = 1'b0;
      bus.ld_en_in     = '0;
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
